// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state encoding and address helpers for the data-memory responder
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WORD_BYTES = 4;

   function automatic logic [29:0] word_index(input logic [31:0] addr);
      return addr[31:2];
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: DEPTH x 32 word store with synchronous write and registered read
module mem_word_array #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // write commit and read capture both happen on the request-acceptance edge
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state responder for the core's word read/write data-memory port
module data_mem_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] dataMemAddress,
   input  logic [31:0] dataMemWriteData,
   output logic [31:0] dataMemReadData,
   output logic        memReady,
   output logic        addrError
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_err, r_rd_ok;
   logic [31:0]      r_hold, w_arr_rdata;
   logic [29:0]      w_idx;
   logic             w_valid, w_accept, w_we, w_re;

   assign w_idx    = word_index(dataMemAddress);
   // full 30-bit compare so high address bits never alias into the array
   assign w_valid  = (dataMemAddress[1:0] == 2'b00) && (w_idx < 30'(DEPTH));
   assign w_accept = (r_state == IDLE) && (MemRead || MemWrite);
   // a simultaneous read+write is serviced as a write only
   assign w_we     = w_accept && MemWrite && w_valid;
   assign w_re     = w_accept && !MemWrite && w_valid;

   mem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (w_idx[AW-1:0]),
      .i_wdata (dataMemWriteData),
      .o_rdata (w_arr_rdata)
   );

   // state and latency counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // next-state, counter and completion strobes
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      memReady   = 1'b0;
      addrError  = 1'b0;
      case (r_state)
         IDLE: if (w_accept) begin
            w_next     = (LATENCY == 1) ? DONE : BUSY;
            w_cnt_next = CNT_W'(LATENCY - 1);
         end
         BUSY: begin
            w_cnt_next = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) w_next = DONE;
         end
         DONE: begin
            memReady  = 1'b1;
            addrError = r_err;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // request status latched at acceptance; read data held after each good read completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err   <= 1'b0;
         r_rd_ok <= 1'b0;
         r_hold  <= '0;
      end else begin
         if (w_accept) begin
            r_err   <= !w_valid;
            r_rd_ok <= w_re;
         end
         if (r_state == DONE && r_rd_ok) r_hold <= w_arr_rdata;
      end
   end

   // fresh array data appears with memReady; otherwise the last good read is held
   assign dataMemReadData = (r_state == DONE && r_rd_ok) ? w_arr_rdata : r_hold;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven scoreboard bench for data_mem_responder
module tb_data_mem_responder;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   logic        clk = 0, rst = 1;
   logic        rd = 0, wr = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic [31:0] rdata;
   logic        ready, err;
   logic        rd1 = 0, wr1 = 0;
   logic [31:0] addr1 = 0, wdata1 = 0;
   logic [31:0] rdata1;
   logic        ready1, err1;

   int   checks = 0, failures = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[14];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(256), .LATENCY(2), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .MemRead(rd), .MemWrite(wr),
      .dataMemAddress(addr), .dataMemWriteData(wdata),
      .dataMemReadData(rdata), .memReady(ready), .addrError(err)
   );

   data_mem_responder #(.DEPTH(256), .LATENCY(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1),
      .dataMemAddress(addr1), .dataMemWriteData(wdata1),
      .dataMemReadData(rdata1), .memReady(ready1), .addrError(err1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_memReady actual=1 required=0 t=%0t", $time);
         end else begin
            mon_e = sb.pop_front();
            chk("rdata", rdata, mon_e.rdata);
            chk("addrError", {31'd0, err}, {31'd0, mon_e.err});
         end
      end
   end

   task automatic do_req(input vec_t v);
      int n;
      bit got;
      @(negedge clk);
      rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
      sb.push_back('{v.exp_rdata, v.exp_err});
      n = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         got = ready;
      end
      chk("latency", 32'(n), 32'd2);
      rd = 0; wr = 0;
   endtask

   initial begin
      int pulses;
      logic [3:0] pat;
      vecs[0]  = '{1'b0, 1'b1, 32'h10,        32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h13,        32'h0,        32'hDEADBEEF, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 32'h0,         32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h400,       32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,         32'h0,        32'hA5A5A5A5, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 32'h20,        32'h12345678, 32'hA5A5A5A5, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h20,        32'h0,        32'h12345678, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'h3FC,       32'hCAFEF00D, 32'h12345678, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h3FC,       32'h0,        32'hCAFEF00D, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0,        32'hCAFEF00D, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 32'h12,        32'h77777777, 32'hCAFEF00D, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 32'h44,        32'h00001111, 32'hCAFEF00D, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 32'h44,        32'h0,        32'h00001111, 1'b0};

      #2;
      chk("reset_memReady", {31'd0, ready}, 32'd0);
      chk("reset_addrError", {31'd0, err}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst = 0;

      for (int i = 0; i < 14; i++) do_req(vecs[i]);

      // LATENCY=1 instance: request held for four edges gives exactly two pulses
      @(negedge clk);
      rd1 = 1; addr1 = 32'h0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pat[i] = ready1;
         if (ready1) pulses++;
      end
      rd1 = 0;
      chk("lat1_pulses", 32'(pulses), 32'd2);
      chk("lat1_pattern", {28'd0, pat}, 32'h5);

      // reset while BUSY drops the pending read
      @(negedge clk);
      rd = 1; addr = 32'h10;
      @(negedge clk);
      rst = 1; rd = 0;
      #1;
      chk("rst_busy_memReady", {31'd0, ready}, 32'd0);
      chk("rst_busy_addrError", {31'd0, err}, 32'd0);
      chk("rst_busy_rdata", rdata, 32'd0);
      @(negedge clk);
      rst = 0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      chk("rst_busy_no_ready", 32'(pulses), 32'd0);
      do_req('{1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface.
- Accepts word read/write requests driven by the core (MemRead, MemWrite, dataMemAddress, dataMemWriteData) and services them against an internal word array.
- Returns read data and a one-cycle completion strobe after a fixed, parameterised latency.
- Lets multi-cycle cores and benches exercise a realistic wait-state memory instead of a zero-latency array.

Parameters:
- DEPTH, 256, number of 32-bit words stored; word index = dataMemAddress[31:2].
- LATENCY, 2, cycles from the request-sampling edge to the memReady cycle; legal range 1..15.
- CNT_W, 4, width of the internal latency counter; must hold LATENCY.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- MemRead  input  1  read request, held by the requester until memReady.
- MemWrite  input  1  write request, held by the requester until memReady.
- dataMemAddress  input  32  byte address of the request.
- dataMemWriteData  input  32  write data.
- dataMemReadData  output  32  read data; valid when memReady=1 for a read.
- memReady  output  1  one-cycle completion strobe.
- addrError  output  1  one-cycle strobe, coincident with memReady, for a rejected request.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: memReady=0, addrError=0, dataMemReadData=0, FSM=IDLE, counter=0. Array contents are not reset.
- Reset mid-operation: the pending response is dropped and no memReady is issued. A write already committed stays committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Samples requests at each rising edge.
  - MemRead|MemWrite=1 accepts the request and latches address and write data.
  - Next state is DONE if LATENCY=1, else BUSY with counter=LATENCY-1.
- Simultaneous MemRead and MemWrite: treated as a write; the read is ignored and no error is raised.
- Address validation at acceptance:
  - The request is rejected if dataMemAddress[1:0]!=0 or word index >= DEPTH.
  - A rejected request performs no array access and still completes with normal latency, with addrError=1.
  - On a rejected read, dataMemReadData keeps its previous value.
- Write commit: happens at the acceptance edge (array[idx] <= dataMemWriteData).
- Read data:
  - Captured from the array at the acceptance edge into a holding register.
  - Driven onto dataMemReadData when memReady rises.
  - Held until the next successful read completes; writes do not change it.
- BUSY: the counter decrements each cycle. When it reaches 1, next state is DONE. Request inputs are ignored in BUSY.
- DONE:
  - memReady=1 for exactly this cycle; addrError=1 if the request was rejected.
  - Next state is IDLE unconditionally.
  - Requests are not sampled in DONE, so a requester still holding the same request during DONE gets no duplicate.
- Timing: a request sampled at edge N gives memReady high between edges N+LATENCY-1 and N+LATENCY. Minimum spacing between accepted requests is LATENCY+1 cycles.
- Read-after-write to the same address with back-to-back requests returns the new data.
- Word index arithmetic: idx = dataMemAddress[31:2]. The range check uses the full 30 bits, with no wrap-around aliasing.

Decomposition:
- Shared package mem_if_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - constant WORD_BYTES=4;
  - a function word_index(addr).
- One natural sub-module: mem_word_array (synchronous write, registered read, DEPTH x 32). The FSM, counter and validation stay in data_mem_responder.

Test Plan:
- Write, then read, LATENCY=2: write addr 0x10, data 0xDEADBEEF, then read 0x10 -> memReady pulses 2 cycles after each sample; read returns 0xDEADBEEF with addrError=0.
- Misaligned read at 0x13 -> memReady and addrError high together after 2 cycles; dataMemReadData unchanged from the previous read.
- Out-of-range write to 0x400 with DEPTH=256 -> addrError=1; a subsequent read of 0x0 returns its previous content.
- MemRead=MemWrite=1, addr 0x20, data 0x12345678 -> treated as a write; a later read of 0x20 returns 0x12345678.
- LATENCY=1 with the request held continuously for 4 cycles -> exactly two memReady pulses, on cycles 1 and 3; no duplicate issued in DONE.
- rst asserted in BUSY after reading 0x10 -> outputs go to 0 immediately, no memReady follows, and the next read of 0x10 still returns 0xDEADBEEF.
